// File: rtl/ram_be_clr.sv
// Simple-dual-port RAM with byte-lane writes, registered read port and a
// post-reset zeroing sequencer. Define RAM_BE_WR_FORWARD_EN for write-first collisions.

module ram_be_clr_lane #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);
    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb begin
        rdata = mem[raddr];
`ifdef RAM_BE_WR_FORWARD_EN
        if (we && (waddr == raddr)) rdata = wdata;
`endif
    end
endmodule

module ram_be_clr #(
    parameter int ADDR_W = 10,
    parameter int BYTES  = 4,
    localparam int DW    = 8 * BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_ready,
    input  logic              i_we,
    input  logic [BYTES-1:0]  i_wbe,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DW-1:0]     i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DW-1:0]     o_rdata,
    output logic              o_rvalid
);
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic {CLEAR, READY} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   rvalid_q, rvalid_d;
    logic [DW-1:0]          rdata_q, rdata_d;

    logic [BYTES-1:0]       lane_we;
    logic [ADDR_W-1:0]      lane_waddr;
    logic [BYTES-1:0][7:0]  lane_wdata;
    logic [BYTES-1:0][7:0]  rd_word;

    // While clearing, the sequencer owns every lane's write port.
    always_comb begin
        lane_we    = '0;
        lane_waddr = i_waddr;
        lane_wdata = i_wdata;
        if (state_q == CLEAR) begin
            lane_we    = '1;
            lane_waddr = cnt_q;
            lane_wdata = '0;
        end else if (i_we) begin
            lane_we    = i_wbe;
        end
    end

    for (genvar k = 0; k < BYTES; k++) begin : g_lane
        ram_be_clr_lane #(.ADDR_W(ADDR_W)) u_lane (
            .clk   (clk),
            .we    (lane_we[k]),
            .waddr (lane_waddr),
            .wdata (lane_wdata[k]),
            .raddr (i_raddr),
            .rdata (rd_word[k])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = READY;
                    ready_d = 1'b1;
                end
            end
            READY: begin
                rvalid_d = i_re;
                if (i_re) rdata_d = rd_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_rvalid = rvalid_q;
    assign o_rdata  = rdata_q;
endmodule
